// File: rtl/branch_target_predictor.sv
// branch_target_predictor
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch looks up the table every cycle; resolved branches train it through a
// two-stage read-modify-write pipeline (U1 reads, U2 writes).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   init_done       table sweep finished, lookups/updates honoured
//   lookup_valid/lookup_pc                     fetch query
//   pred_hit/pred_taken/pred_pc/pred_is_return/pred_is_call   registered answer
//   br_valid/br_pc/br_target/br_taken/br_is_branch/br_is_return/br_is_call
//                   branch-unit training input
module branch_target_predictor #(
   parameter int ENTRIES = 512,
   parameter int TAG_W   = 12
) (
   input  logic        clk,
   input  logic        rst,
   output logic        init_done,
   input  logic        lookup_valid,
   input  logic [31:0] lookup_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_pc,
   output logic        pred_is_return,
   output logic        pred_is_call,
   input  logic        br_valid,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_target,
   input  logic        br_taken,
   input  logic        br_is_branch,
   input  logic        br_is_return,
   input  logic        br_is_call
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [30:0]      target;
      logic             is_branch;
      logic             is_return;
      logic             is_call;
      logic [1:0]       ctr;
   } entry_t;

   localparam int ENT_W = $bits(entry_t);

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      ctr_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      ctr_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   entry_t           mem_r [ENTRIES];
   logic [0:0]       state_r;
   logic [IDX_W-1:0] sweep_r;

   logic [IDX_W-1:0] lk_idx_s;
   logic [TAG_W-1:0] lk_tag_s;
   entry_t           lk_ent_s;
   logic             lk_hit_s;

   logic [IDX_W-1:0] br_idx_s;
   entry_t           u1_rd_s;

   logic             u1_valid_r;
   logic [IDX_W-1:0] u1_idx_r;
   logic [TAG_W-1:0] u1_tag_r;
   logic [30:0]      u1_target_r;
   logic             u1_taken_r;
   logic             u1_is_branch_r;
   logic             u1_is_return_r;
   logic             u1_is_call_r;
   entry_t           u1_ent_r;

   logic             u2_hit_s;
   logic             u2_we_s;
   entry_t           u2_data_s;

   logic             wr_en_s;
   logic [IDX_W-1:0] wr_idx_s;
   entry_t           wr_data_s;

   logic             unused_s;

   assign init_done = (state_r == ST_READY);
   assign lk_idx_s  = lookup_pc[IDX_W+1:2];
   assign lk_tag_s  = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign lk_ent_s  = mem_r[lk_idx_s];
   assign lk_hit_s  = lk_ent_s.valid && (lk_ent_s.tag == lk_tag_s);
   assign br_idx_s  = br_pc[IDX_W+1:2];
   assign unused_s  = ^{lookup_pc, br_pc, br_target, lk_ent_s};

   // Sweep/ready state machine: clears every valid bit after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_INIT;
         sweep_r <= {IDX_W{1'b0}};
      end else begin
         case (state_r)
            ST_INIT: begin
               sweep_r <= sweep_r + IDX_W'(1);
               if (sweep_r == IDX_W'(ENTRIES - 1)) state_r <= ST_READY;
               else                                state_r <= ST_INIT;
            end
            ST_READY: state_r <= ST_READY;
            default: begin
               state_r <= ST_INIT;
               sweep_r <= {IDX_W{1'b0}};
            end
         endcase
      end
   end

   // Registered lookup answer; the array read sees pre-write contents.
   always_ff @(posedge clk) begin
      if (rst || !(state_r == ST_READY && lookup_valid)) begin
         pred_hit       <= 1'b0;
         pred_taken     <= 1'b0;
         pred_pc        <= 32'h0000_0000;
         pred_is_return <= 1'b0;
         pred_is_call   <= 1'b0;
      end else begin
         pred_hit       <= lk_hit_s;
         pred_taken     <= lk_hit_s && (lk_ent_s.ctr[1] || !lk_ent_s.is_branch);
         pred_pc        <= lk_hit_s ? {lk_ent_s.target, 1'b0} : 32'h0000_0000;
         pred_is_return <= lk_hit_s && lk_ent_s.is_return;
         pred_is_call   <= lk_hit_s && lk_ent_s.is_call;
      end
   end

   // U1 read with bypass of the write landing this cycle at the same index.
   always_comb begin
      u1_rd_s = mem_r[br_idx_s];
      if (wr_en_s && (wr_idx_s == br_idx_s)) u1_rd_s = wr_data_s;
      else                                   u1_rd_s = mem_r[br_idx_s];
   end

   // U1 valid bit; training is dropped while the sweep runs.
   always_ff @(posedge clk) begin
      if (rst) u1_valid_r <= 1'b0;
      else     u1_valid_r <= br_valid && (state_r == ST_READY);
   end

   // U1 payload registers (qualified by u1_valid_r).
   always_ff @(posedge clk) begin
      u1_idx_r       <= br_idx_s;
      u1_tag_r       <= br_pc[IDX_W+TAG_W+1:IDX_W+2];
      u1_target_r    <= br_target[31:1];
      u1_taken_r     <= br_taken;
      u1_is_branch_r <= br_is_branch;
      u1_is_return_r <= br_is_return;
      u1_is_call_r   <= br_is_call;
      u1_ent_r       <= u1_rd_s;
   end

   // U2 decision: train a hit, allocate a taken miss, ignore a not-taken miss.
   always_comb begin
      u2_hit_s  = u1_ent_r.valid && (u1_ent_r.tag == u1_tag_r);
      u2_we_s   = 1'b0;
      u2_data_s = u1_ent_r;
      if (u1_valid_r && u2_hit_s) begin
         u2_we_s             = 1'b1;
         u2_data_s.is_branch = u1_is_branch_r;
         u2_data_s.is_return = u1_is_return_r;
         u2_data_s.is_call   = u1_is_call_r;
         if (u1_taken_r) begin
            u2_data_s.ctr    = ctr_inc(u1_ent_r.ctr);
            u2_data_s.target = u1_target_r;
         end else begin
            u2_data_s.ctr    = ctr_dec(u1_ent_r.ctr);
         end
      end else if (u1_valid_r && u1_taken_r) begin
         u2_we_s             = 1'b1;
         u2_data_s.valid     = 1'b1;
         u2_data_s.tag       = u1_tag_r;
         u2_data_s.target    = u1_target_r;
         u2_data_s.is_branch = u1_is_branch_r;
         u2_data_s.is_return = u1_is_return_r;
         u2_data_s.is_call   = u1_is_call_r;
         u2_data_s.ctr       = 2'b10;
      end else begin
         u2_we_s = 1'b0;
      end
   end

   // Single write port shared by the sweep and U2; reset kills any write.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = sweep_r;
      wr_data_s = {ENT_W{1'b0}};
      if (rst) begin
         wr_en_s = 1'b0;
      end else if (state_r == ST_INIT) begin
         wr_en_s = 1'b1;
      end else if (u2_we_s) begin
         wr_en_s   = 1'b1;
         wr_idx_s  = u1_idx_r;
         wr_data_s = u2_data_s;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Table storage (no reset; the sweep invalidates entries).
   always_ff @(posedge clk) begin
      if (wr_en_s) mem_r[wr_idx_s] <= wr_data_s;
   end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor (ENTRIES = 8).
// The driver advances a sequential reference table, pushes the expected
// lookup answer for every cycle, and a monitor pops and compares.
module tb_branch_target_predictor;
   localparam int ENTRIES = 8;
   localparam int TAG_W   = 12;
   localparam int IDX_W   = $clog2(ENTRIES);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init_done;
   logic        lookup_valid = 1'b0;
   logic [31:0] lookup_pc = 32'h0;
   logic        pred_hit, pred_taken, pred_is_return, pred_is_call;
   logic [31:0] pred_pc;
   logic        br_valid = 1'b0;
   logic [31:0] br_pc = 32'h0, br_target = 32'h0;
   logic        br_taken = 1'b0, br_is_branch = 1'b0, br_is_return = 1'b0, br_is_call = 1'b0;

   always #5 clk = ~clk;

   branch_target_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_pc(pred_pc),
      .pred_is_return(pred_is_return), .pred_is_call(pred_is_call),
      .br_valid(br_valid), .br_pc(br_pc), .br_target(br_target), .br_taken(br_taken),
      .br_is_branch(br_is_branch), .br_is_return(br_is_return), .br_is_call(br_is_call)
   );

   typedef struct {
      int unsigned cyc;
      logic        hit, taken, ret, call;
      logic [31:0] pc;
   } exp_t;

   typedef struct {
      bit          v;
      logic [31:0] pc, tgt;
      bit          taken, br, ret, call;
   } upd_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   // reference table, one row per index
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   logic [31:0] m_target[ENTRIES];
   bit          m_br [ENTRIES], m_ret [ENTRIES], m_call [ENTRIES];
   int          m_ctr[ENTRIES];
   upd_t        pend_new, pend_old;
   bit          ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return (pc >> (2 + IDX_W)) & ((32'd1 << TAG_W) - 32'd1);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      pend_new = '{default: 0};
      pend_old = '{default: 0};
      ready    = 1'b0;
   endtask

   task automatic model_apply(input upd_t u);
      int i;
      bit hit;
      if (!u.v) return;
      i   = idx_of(u.pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(u.pc));
      if (hit) begin
         m_br[i] = u.br; m_ret[i] = u.ret; m_call[i] = u.call;
         if (u.taken) begin
            m_ctr[i]    = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
            m_target[i] = u.tgt & 32'hFFFF_FFFE;
         end else begin
            m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
         end
      end else if (u.taken) begin
         m_valid[i] = 1'b1; m_tag[i] = tag_of(u.pc);
         m_target[i] = u.tgt & 32'hFFFF_FFFE;
         m_br[i] = u.br; m_ret[i] = u.ret; m_call[i] = u.call;
         m_ctr[i] = 2;
      end
   endtask

   // One cycle: predict, queue the expectation, drive, advance to next negedge.
   task automatic step(input bit lv, input logic [31:0] lpc, input bit bv,
                       input logic [31:0] bpc, input logic [31:0] btgt,
                       input bit btk, input bit bbr, input bit bret, input bit bcall);
      exp_t e;
      int   i;
      if (ready) model_apply(pend_old);
      pend_old = pend_new;
      e = '{cyc: cyc, hit: 1'b0, taken: 1'b0, ret: 1'b0, call: 1'b0, pc: 32'h0};
      if (ready && lv && !rst) begin
         i = idx_of(lpc);
         if (m_valid[i] && (m_tag[i] == tag_of(lpc))) begin
            e.hit   = 1'b1;
            e.taken = (m_ctr[i] >= 2) || !m_br[i];
            e.pc    = m_target[i];
            e.ret   = m_ret[i];
            e.call  = m_call[i];
         end
      end
      pend_new = '{v: bv && ready && !rst, pc: bpc, tgt: btgt, taken: btk, br: bbr, ret: bret, call: bcall};
      sb_q.push_back(e);
      lookup_valid = lv;  lookup_pc = lpc;
      br_valid = bv; br_pc = bpc; br_target = btgt; br_taken = btk;
      br_is_branch = bbr; br_is_return = bret; br_is_call = bcall;
      @(negedge clk);
   endtask

   task automatic look(input logic [31:0] lpc);
      step(1'b1, lpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                      input bit br, input bit ret, input bit call, input logic [31:0] lpc);
      step(1'b1, lpc, 1'b1, pc, tgt, tk, br, ret, call);
   endtask

   task automatic init_step();
      step(1'b1, 32'h100, 1'b1, 32'h100, 32'h240, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // Reset, optionally re-pulsed at sweep index abort_at, then check init_done.
   task automatic do_reset(input int abort_at);
      model_clear();
      rst = 1'b1; init_step(); init_step(); rst = 1'b0;
      if (abort_at >= 0) begin
         for (int k = 0; k < abort_at; k++) begin
            chk("init_done_pre_abort", {63'd0, init_done}, 64'd0);
            init_step();
         end
         rst = 1'b1; init_step(); init_step(); rst = 1'b0;
      end
      for (int k = 0; k < ENTRIES; k++) begin
         chk($sformatf("init_done_c%0d", k), {63'd0, init_done}, 64'd0);
         init_step();
      end
      chk("init_done_ready", {63'd0, init_done}, 64'd1);
      ready = 1'b1;
   endtask

   task automatic rand_steps(input int n);
      logic [31:0] pc, lpc;
      bit br, tk;
      for (int s = 0; s < n; s++) begin
         pc  = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
         if ($urandom_range(0, 7) == 0) pc = pc | 32'h0001_0000;
         lpc = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
         br  = $urandom_range(0, 3) != 0;
         tk  = br ? bit'($urandom_range(0, 1)) : 1'b1;
         step($urandom_range(0, 3) != 0, lpc, bit'($urandom_range(0, 1)), pc, $urandom,
              tk, br, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      end
   endtask

   // Monitor: compare each answer one cycle after its request.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            chk($sformatf("lookup_c%0d", e.cyc),
                {28'd0, pred_hit, pred_taken, pred_is_return, pred_is_call, pred_pc},
                {28'd0, e.hit, e.taken, e.ret, e.call, e.pc});
         end
      end
   end

   initial begin
      int guard;
      @(negedge clk);
      do_reset(-1);
      look(32'h100);
      // allocation
      upd(32'h100, 32'h240, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
      look(32'h100); look(32'h100);
      // counter down to saturation, forwarding back-to-back
      for (int i = 0; i < 4; i++) upd(32'h100, 32'h240, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
      look(32'h100); look(32'h100); look(32'h100);
      for (int i = 0; i < 3; i++) upd(32'h100, 32'h260, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
      look(32'h100); look(32'h100); look(32'h100);
      // tag conflict
      upd(32'h100, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
      upd(32'h100 + 32'(4 * ENTRIES), 32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
      look(32'h100); look(32'h120); look(32'h100); look(32'h120);
      upd(32'h140, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 32'h120);
      look(32'h120); look(32'h120); look(32'h140);
      // jump/return and call
      upd(32'h204, 32'h81, 1'b1, 1'b0, 1'b1, 1'b0, 32'h204);
      look(32'h204); look(32'h204);
      upd(32'h208, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h208);
      look(32'h208); look(32'h208);
      // lookup colliding with the U2 write of the same index
      upd(32'h120, 32'h700, 1'b1, 1'b1, 1'b0, 1'b0, 32'h120);
      look(32'h120); look(32'h120);
      rand_steps(400);
      // reset in READY with a second pulse mid-sweep
      do_reset(3);
      look(32'h100); look(32'h120); look(32'h204); look(32'h208);
      rand_steps(150);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      guard = 0;
      while (sb_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d answers outstanding, expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
